// File: rtl/vga_plot_arbiter.sv
// Two-requester round-robin pixel plotter with a full-screen clear engine.
// Drives the VGA adapter plot port with at most one registered pixel write per cycle.
module vga_plot_arbiter #(
    parameter  int unsigned SCREEN_W = 160,
    parameter  int unsigned SCREEN_H = 120,
    localparam int unsigned XW       = 8,
    localparam int unsigned YW       = 7,
    localparam int unsigned CW       = 3
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          req0,
    input  logic          req1,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour0,
    input  logic [CW-1:0] colour1,
    output logic          ack0,
    output logic          ack1,
    input  logic          clear_start,
    input  logic [CW-1:0] clear_colour,
    output logic          busy,
    output logic          clear_done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_write
);
    // Row counter has one spare bit so it can step one past the last row as the end marker.
    localparam int unsigned YCW = YW + 1;

    typedef enum logic [1:0] {IDLE, SERVE, CLEAR} state_t;

    state_t        state, next_state;
    logic          favour1, favour1_d;
    logic [CW-1:0] clr_colour, clr_colour_d;
    logic [XW-1:0] cx, cx_d;
    logic [YCW-1:0] cy, cy_d;

    logic          ack0_d, ack1_d, busy_d, clear_done_d, write_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic [CW-1:0] colour_d;

    logic gnt0_c, gnt1_c, elig0_c, elig1_c, in0_c, in1_c, clear_end_c;

    // A requester whose ack is currently high is still showing the pixel just consumed.
    assign elig0_c     = req0 & ~ack0;
    assign elig1_c     = req1 & ~ack1;
    assign in0_c       = ({1'b0, x0} < (XW+1)'(SCREEN_W)) && ({1'b0, y0} < (YW+1)'(SCREEN_H));
    assign in1_c       = ({1'b0, x1} < (XW+1)'(SCREEN_W)) && ({1'b0, y1} < (YW+1)'(SCREEN_H));
    assign clear_end_c = (cy == YCW'(SCREEN_H));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, SERVE: begin
                if (clear_start)            next_state = CLEAR;
                else if (gnt0_c || gnt1_c)  next_state = SERVE;
                else                        next_state = IDLE;
            end
            CLEAR:   if (clear_end_c) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Round-robin grant: favour1 selects the winner only when both are eligible.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (state != CLEAR) begin
            if (elig0_c && elig1_c) begin
                gnt0_c = ~favour1;
                gnt1_c = favour1;
            end else begin
                gnt0_c = elig0_c;
                gnt1_c = elig1_c;
            end
        end
    end

    always_comb begin
        write_d      = 1'b0;
        x_d          = '0;
        y_d          = '0;
        colour_d     = '0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        clear_done_d = 1'b0;
        favour1_d    = favour1;
        clr_colour_d = clr_colour;
        cx_d         = cx;
        cy_d         = cy;
        if (state != CLEAR) begin
            if (gnt0_c) begin
                write_d   = in0_c;
                x_d       = x0;
                y_d       = y0;
                colour_d  = colour0;
                ack0_d    = 1'b1;
                favour1_d = 1'b1;
            end else if (gnt1_c) begin
                write_d   = in1_c;
                x_d       = x1;
                y_d       = y1;
                colour_d  = colour1;
                ack1_d    = 1'b1;
                favour1_d = 1'b0;
            end
            if (clear_start) begin
                clr_colour_d = clear_colour;
                cx_d         = '0;
                cy_d         = '0;
            end
        end else if (clear_end_c) begin
            clear_done_d = 1'b1;
        end else begin
            write_d  = 1'b1;
            x_d      = cx;
            y_d      = cy[YW-1:0];
            colour_d = clr_colour;
            if (cx == XW'(SCREEN_W - 1)) begin
                cx_d = '0;
                cy_d = cy + YCW'(1);
            end else begin
                cx_d = cx + XW'(1);
            end
        end
        busy_d = (next_state == CLEAR);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_write  <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            busy       <= 1'b0;
            clear_done <= 1'b0;
            favour1    <= 1'b0;
            clr_colour <= '0;
            cx         <= '0;
            cy         <= '0;
        end else begin
            vga_write  <= write_d;
            vga_x      <= x_d;
            vga_y      <= y_d;
            vga_colour <= colour_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            busy       <= busy_d;
            clear_done <= clear_done_d;
            favour1    <= favour1_d;
            clr_colour <= clr_colour_d;
            cx         <= cx_d;
            cy         <= cy_d;
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Scoreboard bench for vga_plot_arbiter: expected output events are queued with the
// stimulus and a negedge monitor pops and compares every ack/write/clear_done event.
`timescale 1ns/1ps
module tb_vga_plot_arbiter;

    logic       clock = 1'b0;
    logic       resetn;
    logic       req0, req1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour0, colour1;
    logic       ack0, ack1;
    logic       clear_start;
    logic [2:0] clear_colour;
    logic       busy, clear_done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_write;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    typedef struct {
        logic       a0, a1, w, done;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        int         gap;   // >0: event must follow the previous one within this many cycles
    } evt_t;

    evt_t exp_q[$];
    pix_t q0[$];
    pix_t q1[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    vga_plot_arbiter dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .req1(req1), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .colour0(colour0), .colour1(colour1), .ack0(ack0), .ack1(ack1),
        .clear_start(clear_start), .clear_colour(clear_colour),
        .busy(busy), .clear_done(clear_done),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_write(vga_write)
    );

    always #10 clock = ~clock;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic evt_t mk(logic a0, logic a1, logic w, logic d,
                                logic [7:0] x, logic [6:0] y, logic [2:0] c, int gap);
        evt_t e;
        e.a0 = a0; e.a1 = a1; e.w = w; e.done = d;
        e.x = x; e.y = y; e.c = c; e.gap = gap;
        return e;
    endfunction

    function automatic pix_t px(logic [7:0] x, logic [6:0] y, logic [2:0] c);
        pix_t p;
        p.x = x; p.y = y; p.c = c;
        return p;
    endfunction

    task automatic check(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic push_clear(input logic [2:0] c, input int npix);
        int k;
        k = 0;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++) begin
                if (k < npix)
                    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'(xx), 7'(yy), c, (k == 0) ? 0 : 1));
                k++;
            end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < budget) begin
            @(posedge clock); #1;
            t++;
        end
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vga_write"}, int'(vga_write), 0);
        check({tag, "_vga_x"}, int'(vga_x), 0);
        check({tag, "_vga_y"}, int'(vga_y), 0);
        check({tag, "_vga_colour"}, int'(vga_colour), 0);
        check({tag, "_ack0"}, int'(ack0), 0);
        check({tag, "_ack1"}, int'(ack1), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_clear_done"}, int'(clear_done), 0);
    endtask

    // Monitor: every DUT output event is matched against the head of the scoreboard.
    initial begin : monitor
        int   cyc, last;
        evt_t e;
        cyc = 0;
        last = 0;
        forever begin
            @(negedge clock);
            cyc++;
            if (ack0 || ack1 || vga_write || clear_done) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got a0=%0b a1=%0b w=%0b done=%0b (%0d,%0d,%0d) expected none",
                             ack0, ack1, vga_write, clear_done, vga_x, vga_y, vga_colour);
                end else begin
                    e = exp_q.pop_front();
                    if (ack0 !== e.a0 || ack1 !== e.a1 || vga_write !== e.w || clear_done !== e.done ||
                        (e.w && (vga_x !== e.x || vga_y !== e.y || vga_colour !== e.c))) begin
                        n_fail++;
                        $display("FAIL event: got a0=%0b a1=%0b w=%0b done=%0b (%0d,%0d,%0d) expected a0=%0b a1=%0b w=%0b done=%0b (%0d,%0d,%0d)",
                                 ack0, ack1, vga_write, clear_done, vga_x, vga_y, vga_colour,
                                 e.a0, e.a1, e.w, e.done, e.x, e.y, e.c);
                    end
                    if (e.gap > 0) begin
                        n_tests++;
                        if (cyc - last > e.gap) begin
                            n_fail++;
                            $display("FAIL event_gap: got %0d cycles expected <= %0d", cyc - last, e.gap);
                        end
                    end
                end
                last = cyc;
            end
        end
    end

    // Requester 0: holds a pixel until acked, replaces or drops it on the edge ending the ack cycle.
    initial begin : drv0
        pix_t p;
        int   t;
        req0 = 1'b0; x0 = '0; y0 = '0; colour0 = '0;
        forever begin
            @(posedge clock); #1;
            if (q0.size() > 0) begin
                p = q0.pop_front();
                req0 = 1'b1; x0 = p.x; y0 = p.y; colour0 = p.c;
                t = 0;
                do begin
                    @(posedge clock); #1;
                    t++;
                end while (!ack0 && t < 30000);
                if (!ack0) begin
                    n_tests++; n_fail++;
                    $display("FAIL ack0_timeout: got no ack after %0d cycles expected ack", t);
                end
            end else begin
                req0 = 1'b0;
            end
        end
    end

    initial begin : drv1
        pix_t p;
        int   t;
        req1 = 1'b0; x1 = '0; y1 = '0; colour1 = '0;
        forever begin
            @(posedge clock); #1;
            if (q1.size() > 0) begin
                p = q1.pop_front();
                req1 = 1'b1; x1 = p.x; y1 = p.y; colour1 = p.c;
                t = 0;
                do begin
                    @(posedge clock); #1;
                    t++;
                end while (!ack1 && t < 30000);
                if (!ack1) begin
                    n_tests++; n_fail++;
                    $display("FAIL ack1_timeout: got no ack after %0d cycles expected ack", t);
                end
            end else begin
                req1 = 1'b0;
            end
        end
    end

    initial begin : main
        resetn = 1'b0;
        clear_start = 1'b0;
        clear_colour = '0;
        repeat (3) @(posedge clock);
        #1;
        check_zero_outputs("reset");
        @(negedge clock); resetn = 1'b1;

        // Single request from requester 0.
        @(negedge clock);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd10, 7'd20, 3'd5, 0));
        q0.push_back(px(8'd10, 7'd20, 3'd5));
        wait_drain("single_drain", 50);
        repeat (5) @(negedge clock);

        // Both requesters continuously active from reset: strict 0,1,0,1 at one pixel per cycle.
        @(negedge clock); resetn = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);
        q0.push_back(px(8'd0, 7'd0, 3'd1));     q1.push_back(px(8'd159, 7'd119, 3'd7));
        q0.push_back(px(8'd1, 7'd0, 3'd2));     q1.push_back(px(8'd158, 7'd119, 3'd6));
        q0.push_back(px(8'd2, 7'd0, 3'd3));     q1.push_back(px(8'd157, 7'd119, 3'd5));
        q0.push_back(px(8'd3, 7'd0, 3'd4));     q1.push_back(px(8'd156, 7'd119, 3'd4));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 7'd0, 3'd1, 0));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd159, 7'd119, 3'd7, 1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd1, 7'd0, 3'd2, 1));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd158, 7'd119, 3'd6, 1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd2, 7'd0, 3'd3, 1));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd157, 7'd119, 3'd5, 1));
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd3, 7'd0, 3'd4, 1));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd156, 7'd119, 3'd4, 1));
        wait_drain("alternate_drain", 100);
        repeat (5) @(negedge clock);

        // Off-screen requests are acknowledged without a write.
        @(negedge clock);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 0));
        q0.push_back(px(8'd160, 7'd5, 3'd2));
        wait_drain("oob_x_drain", 50);
        @(negedge clock);
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 7'd0, 3'd0, 0));
        q1.push_back(px(8'd0, 7'd120, 3'd1));
        wait_drain("oob_y_drain", 50);
        repeat (5) @(negedge clock);

        // Full clear with colour 3.
        @(negedge clock);
        push_clear(3'd3, 19200);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 7'd0, 3'd0, 1));
        clear_start = 1'b1; clear_colour = 3'd3;
        @(posedge clock); #1;
        clear_start = 1'b0; clear_colour = 3'd0;
        check("clear_busy_high", int'(busy), 1);
        wait_drain("clear_drain", 25000);
        check("clear_busy_low", int'(busy), 0);
        check("clear_done_single", int'(clear_done), 0);
        repeat (5) @(negedge clock);

        // Request and second clear_start during a clear.
        @(negedge clock);
        push_clear(3'd2, 19200);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 7'd0, 3'd0, 1));
        exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 8'd50, 7'd60, 3'd7, 2));
        clear_start = 1'b1; clear_colour = 3'd2;
        @(negedge clock);
        clear_start = 1'b0; clear_colour = 3'd0;
        repeat (100) @(negedge clock);
        q1.push_back(px(8'd50, 7'd60, 3'd7));
        repeat (50) @(negedge clock);
        check("midclear_ack1_low", int'(ack1), 0);
        check("midclear_busy", int'(busy), 1);
        clear_start = 1'b1; clear_colour = 3'd6;
        @(negedge clock);
        clear_start = 1'b0; clear_colour = 3'd0;
        wait_drain("midclear_drain", 25000);
        repeat (5) @(negedge clock);

        // Reset during a clear, right after write 5000.
        @(negedge clock);
        push_clear(3'd1, 5000);
        clear_start = 1'b1; clear_colour = 3'd1;
        @(negedge clock);
        clear_start = 1'b0; clear_colour = 3'd0;
        wait_drain("abort_drain", 6000);
        resetn = 1'b0;
        #1;
        check_zero_outputs("abort");
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (30) @(negedge clock);
        check("abort_idle_busy", int'(busy), 0);
        exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 8'd5, 7'd6, 3'd7, 0));
        q0.push_back(px(8'd5, 7'd6, 3'd7));
        wait_drain("post_abort_drain", 50);
        repeat (5) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
